// File: rtl/ysyx_22050039_ifu.sv
// ysyx_22050039_ifu: instruction fetch unit, one outstanding word fetch,
// hands inst+pc to decode over valid/ready and takes next-PC redirects.
// Ports:
//   clk, rst            clock, async active-low reset
//   imem_req_valid/ready/addr   fetch request channel (addr == pc)
//   imem_rsp_valid/data         fetch response (single-cycle pulse)
//   inst, pc, inst_valid, inst_ready   decode handshake
//   pc_wen, pc_wdata, halt      retire-time redirect / ebreak stop
//   fetch_fault, halted         sticky misaligned-target flag, halt status
module ysyx_22050039_ifu #(
   parameter int                XLEN     = 64,
   parameter int                INST_LEN = 32,
   parameter logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [XLEN-1:0]     imem_addr,
   input  logic                imem_rsp_valid,
   input  logic [INST_LEN-1:0] imem_rsp_data,
   output logic [INST_LEN-1:0] inst,
   output logic [XLEN-1:0]     pc,
   output logic                inst_valid,
   input  logic                inst_ready,
   input  logic                pc_wen,
   input  logic [XLEN-1:0]     pc_wdata,
   input  logic                halt,
   output logic                fetch_fault,
   output logic                halted
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_OUT,
      S_HALT
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [XLEN-1:0]     r_pc;
   logic [XLEN-1:0]     w_pc_nxt;
   logic [INST_LEN-1:0] r_inst;
   logic                r_fault;
   logic                w_ld_inst;
   logic                w_set_fault;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ld_inst   = 1'b0;
      w_set_fault = 1'b0;
      unique case (r_state)
         S_REQ: begin
            if (imem_req_ready)
               w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               w_ld_inst   = 1'b1;
               w_state_nxt = S_OUT;
            end
         end
         S_OUT: begin
            if (inst_ready) begin
               // halt outranks a redirect; a misaligned
               // target stops fetch without moving pc
               if (halt) begin
                  w_state_nxt = S_HALT;
               end else if (pc_wen && (pc_wdata[1:0] != 2'b00)) begin
                  w_set_fault = 1'b1;
                  w_state_nxt = S_HALT;
               end else begin
                  w_pc_nxt    = pc_wen ? pc_wdata
                                       : r_pc + XLEN'(4);
                  w_state_nxt = S_REQ;
               end
            end
         end
         S_HALT: begin
            w_state_nxt = S_HALT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_REQ;
         r_pc    <= RESET_PC;
         r_inst  <= '0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         if (w_ld_inst)
            r_inst <= imem_rsp_data;
         if (w_set_fault)
            r_fault <= 1'b1;
      end
   end

   // request is masked while reset is held so nothing
   // escapes to memory before the FSM is released
   assign imem_req_valid = rst && (r_state == S_REQ);
   assign imem_addr      = r_pc;
   assign pc             = r_pc;
   assign inst           = r_inst;
   assign inst_valid     = (r_state == S_OUT);
   assign halted         = (r_state == S_HALT);
   assign fetch_fault    = r_fault;

endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// Randomized bench for ysyx_22050039_ifu against a transaction-level
// model of the fetch/retire rules.
module tb_ysyx_22050039_ifu;

   localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [63:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic [31:0] inst;
   logic [63:0] pc;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic        pc_wen = 1'b0;
   logic [63:0] pc_wdata = '0;
   logic        halt = 1'b0;
   logic        fetch_fault;
   logic        halted;

   ysyx_22050039_ifu dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst           (inst),
      .pc             (pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .pc_wen         (pc_wen),
      .pc_wdata       (pc_wdata),
      .halt           (halt),
      .fetch_fault    (fetch_fault),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // model: fetch phase 0=request 1=awaiting data 2=holding 3=stopped
   int          m_ph;
   int          lat;
   logic [63:0] m_pc;
   logic [31:0] m_inst;
   logic        m_fault;
   logic [31:0] d;

   function automatic logic [63:0] pick_target();
      logic [63:0] t;
      case ($urandom_range(0, 4))
         0: t = 64'h0000_0000_8000_0100;
         1: t = 64'h0000_0000_8000_0102;
         2: t = {$urandom, $urandom} & ~64'h3;
         3: t = 64'hFFFF_FFFF_FFFF_FFFC;
         default: t = {$urandom, $urandom};
      endcase
      return t;
   endfunction

   task automatic model_reset();
      m_ph    = 0;
      m_pc    = RPC;
      m_inst  = '0;
      m_fault = 1'b0;
   endtask

   task automatic chk_reset();
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_inst_valid", 64'(inst_valid), 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_fault", 64'(fetch_fault), 64'd0);
      chk("rst_pc", pc, RPC);
      chk("rst_inst", 64'(inst), 64'd0);
   endtask

   initial begin
      model_reset();
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk);
         if (!rst) begin
            chk_reset();
            rst = 1'b1;
         end else begin
            chk("req_valid", 64'(imem_req_valid), 64'(m_ph == 0));
            chk("inst_valid", 64'(inst_valid), 64'(m_ph == 2));
            chk("halted", 64'(halted), 64'(m_ph == 3));
            chk("fault", 64'(fetch_fault), 64'(m_fault));
            chk("addr", imem_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("inst", 64'(inst), 64'(m_inst));
            chk("excl", 64'(imem_req_valid && inst_valid), 64'd0);
            if ($urandom_range(0, 199) == 0 ||
                (m_ph == 3 && $urandom_range(0, 9) == 0)) begin
               rst = 1'b0;
               #1;
               model_reset();
               chk_reset();
               continue;
            end
         end
         imem_req_ready = $urandom_range(0, 9) < 6;
         imem_rsp_valid = $urandom_range(0, 9) == 0;
         imem_rsp_data  = 32'hDEAD_BEEF;
         inst_ready     = $urandom_range(0, 1) == 1;
         halt           = $urandom_range(0, 19) == 0;
         pc_wen         = $urandom_range(0, 2) == 0;
         pc_wdata       = pick_target();
         case (m_ph)
            0: begin
               if (imem_req_ready) begin
                  m_ph = 1;
                  lat  = $urandom_range(0, 3);
               end
            end
            1: begin
               if (lat == 0) begin
                  d = ($urandom_range(0, 3) == 0) ? 32'h0000_0013
                                                  : $urandom;
                  imem_rsp_valid = 1'b1;
                  imem_rsp_data  = d;
                  m_inst = d;
                  m_ph   = 2;
               end else begin
                  imem_rsp_valid = 1'b0;
                  lat--;
               end
            end
            2: begin
               if (inst_ready) begin
                  if (halt) begin
                     m_ph = 3;
                  end else if (pc_wen && pc_wdata[1:0] != 2'b00) begin
                     m_fault = 1'b1;
                     m_ph    = 3;
                  end else begin
                     m_pc = pc_wen ? pc_wdata : m_pc + 64'd4;
                     m_ph = 0;
                  end
               end
            end
            default: ;
         endcase
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_22050039_ifu.md
Name: ysyx_22050039_ifu

Overview:
Instruction fetch unit, directly upstream of the decode stage. Holds the architectural PC and issues one word fetch at a time to instruction memory over a valid/ready request channel plus a response-valid channel. It presents the fetched instruction with its PC to decode under a valid/ready handshake. It accepts the next-PC redirect (pc_wen/pc_wdata) that decode/execute produce for the instruction being retired.

Parameters:
- XLEN, 64, width of PC and addresses.
- INST_LEN, 32, instruction width.
- RESET_PC, 64'h0000_0000_8000_0000, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  XLEN  fetch address; always equals pc.
- imem_rsp_valid  in  1  response data valid (one cycle pulse).
- imem_rsp_data  in  INST_LEN  fetched instruction word.
- inst  out  INST_LEN  instruction to decode (registered).
- pc  out  XLEN  PC of inst / current fetch PC.
- inst_valid  out  1  inst holds a valid instruction.
- inst_ready  in  1  decode retires inst this cycle.
- pc_wen  in  1  redirect for retiring instruction.
- pc_wdata  in  XLEN  redirect target.
- halt  in  1  stop fetching (ebreak retired).
- fetch_fault  out  1  sticky: misaligned redirect target seen.
- halted  out  1  FSM in S_HALT.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=S_REQ, inst=0, inst_valid=0, imem_req_valid=0 during reset, fetch_fault=0, halted=0.
- States: S_REQ, S_WAIT, S_OUT, S_HALT. Encoding is free; outputs are decoded from state.
- S_REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready=1 -> S_WAIT. The request stays held while ready=0 (addr stable).
- S_WAIT: imem_req_valid=0. On imem_rsp_valid=1, inst<=imem_rsp_data -> S_OUT. There is no timeout; the FSM waits indefinitely.
- S_OUT: inst_valid=1, inst/pc stable until handshake. The handshake occurs on inst_ready=1:
  - halt=1 -> S_HALT, pc unchanged. halt has priority over pc_wen.
  - else if pc_wen=1 and pc_wdata[1:0]!=0 -> fetch_fault<=1, -> S_HALT, pc unchanged.
  - else pc <= pc_wen ? pc_wdata : pc+4 (modulo 2^XLEN, wraps), -> S_REQ.
- pc_wen, pc_wdata and halt are sampled only on the S_OUT handshake cycle and ignored otherwise.
- imem_rsp_valid outside S_WAIT is ignored: no state or inst change.
- Minimum fetch latency: S_REQ(ready=1) -> S_WAIT(rsp=1) -> S_OUT. inst_valid rises 2 cycles after the request is accepted, so the best throughput is 1 instruction per 3 cycles.
- S_HALT: absorbing until reset. imem_req_valid=0, inst_valid=0, halted=1.
- Reset asserted mid-transaction (any state): immediate return to reset values; any later stale response is ignored because the FSM is in S_REQ.
- inst_valid is never asserted in the same cycle as imem_req_valid.

Test Plan:
- Reset then memory with ready=1 and 1-cycle response returning 0x00000013 -> first request addr=0x80000000. inst_valid=1 with inst=0x00000013, pc=0x80000000. With inst_ready=1 the next addr is 0x80000004.
- imem_req_ready held 0 for 5 cycles -> imem_req_valid stays 1 with addr stable. Transition to S_WAIT happens only on the ready cycle.
- Deliver inst, hold inst_ready=0 for 4 cycles, pulse an unsolicited imem_rsp_valid with 0xDEADBEEF -> inst remains unchanged and inst_valid stays 1.
- Handshake with pc_wen=1, pc_wdata=0x80000100 -> next imem_addr=0x80000100.
- Handshake with pc_wen=1, pc_wdata=0x80000102 -> fetch_fault=1, halted=1, no further requests.
- Handshake with halt=1 (ebreak, 0x00100073) -> halted=1, no requests. Then assert rst=0 in S_WAIT of a new run -> pc=0x80000000, state S_REQ, and a late response is ignored.
